// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port (instruction fetch / load-store) arbiter in front of a
// single-port asynchronous-read RAM. Round-robin on conflict, one access per
// cycle, fixed one-cycle read latency, sticky error flag for illegal accesses.
module dram_arbiter #(
  parameter int RAM_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic [RAM_AW-1:0] ram_a,
  output logic [31:0]       ram_d,
  output logic              ram_we,
  input  logic [31:0]       ram_spo,
  output logic              err
);

  // Word aligned and inside the RAM window.
  function automatic logic f_legal(input logic [31:0] a);
    f_legal = (a[1:0] == 2'b00) && ((a >> (RAM_AW + 2)) == 32'd0);
  endfunction

  // 1 = load/store held the most recent grant, so fetch wins the next conflict.
  logic        r_last_ls;
  logic        r_if_rvalid;
  logic        r_ls_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_ls_rdata;
  logic        r_err;

  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_any_gnt;
  logic [31:0] w_addr;
  logic        w_legal;

  // Combinational round-robin grant, suppressed during reset.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (rst) begin
      w_if_gnt = 1'b0;
      w_ls_gnt = 1'b0;
    end else begin
      w_ls_gnt = ls_req && (!if_req || !r_last_ls);
      w_if_gnt = if_req && !w_ls_gnt;
    end
  end

  assign w_any_gnt = w_if_gnt || w_ls_gnt;

  // Select the granted address; zero when idle.
  always_comb begin
    w_addr = 32'd0;
    if (w_ls_gnt) begin
      w_addr = ls_addr;
    end else if (w_if_gnt) begin
      w_addr = if_addr;
    end else begin
      w_addr = 32'd0;
    end
  end

  assign w_legal = f_legal(w_addr);

  assign if_gnt = w_if_gnt;
  assign ls_gnt = w_ls_gnt;
  assign ram_a  = w_any_gnt ? w_addr[RAM_AW+1:2] : {RAM_AW{1'b0}};
  assign ram_d  = w_any_gnt ? ls_wdata : 32'd0;
  assign ram_we = w_ls_gnt && ls_we && w_legal;

  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rvalid = r_ls_rvalid;
  assign ls_rdata  = r_ls_rdata;
  assign err       = r_err;

  // Response pipeline: capture RAM data at the grant edge, pulse rvalid next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_ls   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_ls_rdata  <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_ls_rvalid <= w_ls_gnt;
      if (w_any_gnt) begin
        r_last_ls <= w_ls_gnt;
      end
      if (w_if_gnt) begin
        r_if_rdata <= w_legal ? ram_spo : 32'd0;
      end
      if (w_ls_gnt) begin
        if (!w_legal) begin
          r_ls_rdata <= 32'd0;
        end else if (!ls_we) begin
          r_ls_rdata <= ram_spo;
        end
        // legal store: acknowledge only, load data register keeps its value
      end
      if (w_any_gnt && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a reference model predicts grants and
// RAM-side outputs each cycle and pushes the expected response state into a
// scoreboard queue, which is popped and compared one clock later.
module tb_dram_arbiter;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = 32'd0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [31:0]   ls_addr = 32'd0;
  logic [31:0]   ls_wdata = 32'd0;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_d;
  logic          ram_we;
  logic [31:0]   ram_spo = 32'd0;
  logic          err;

  dram_arbiter #(.RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          vif;
    bit          vls;
    logic [31:0] ifd;
    logic [31:0] lsd;
    bit          er;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          m_last_ls = 1'b0;
  logic [31:0] m_if_rdata = 32'd0;
  logic [31:0] m_ls_rdata = 32'd0;
  bit          m_err = 1'b0;
  bit          m_if_wait = 1'b0;
  bit          m_ls_wait = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive, check RAM side, score, then check the response.
  task automatic step(input bit ifr, input logic [31:0] ifa,
                      input bit lsr, input bit we, input logic [31:0] lsa,
                      input logic [31:0] wd, input logic [31:0] spo);
    bit          gl;
    bit          gi;
    bit          lg;
    logic [31:0] a;
    exp_t        e;
    @(negedge clk);
    if_req = ifr; if_addr = ifa;
    ls_req = lsr; ls_we = we; ls_addr = lsa; ls_wdata = wd;
    ram_spo = spo;
    gl = lsr && (!ifr || !m_last_ls);
    gi = ifr && !gl;
    a  = gl ? lsa : (gi ? ifa : 32'd0);
    lg = (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    #1;
    check("if_gnt", {31'd0, if_gnt}, {31'd0, gi});
    check("ls_gnt", {31'd0, ls_gnt}, {31'd0, gl});
    check("ram_a", {{(32-AW){1'b0}}, ram_a}, (gl || gi) ? {{(32-AW){1'b0}}, a[AW+1:2]} : 32'd0);
    check("ram_d", ram_d, (gl || gi) ? wd : 32'd0);
    check("ram_we", {31'd0, ram_we}, {31'd0, gl && we && lg});
    if (gl || gi) m_last_ls = gl;
    if (gi) m_if_rdata = lg ? spo : 32'd0;
    if (gl) begin
      if (!lg) m_ls_rdata = 32'd0;
      else if (!we) m_ls_rdata = spo;
    end
    if ((gl || gi) && !lg) m_err = 1'b1;
    m_if_wait = ifr && !gi;
    m_ls_wait = lsr && !gl;
    e.vif = gi; e.vls = gl; e.ifd = m_if_rdata; e.lsd = m_ls_rdata; e.er = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("if_rvalid", {31'd0, if_rvalid}, {31'd0, e.vif});
    check("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, e.vls});
    check("if_rdata", if_rdata, e.ifd);
    check("ls_rdata", ls_rdata, e.lsd);
    check("err", {31'd0, err}, {31'd0, e.er});
  endtask

  // Assert reset in the middle of a conflicting, illegal grant cycle.
  task automatic reset_mid_grant();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0003;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'hFFFF_0001; ls_wdata = 32'hA5A5_A5A5;
    ram_spo = 32'h5555_AAAA;
    #2;
    rst = 1'b1;
    #1;
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_ls_gnt", {31'd0, ls_gnt}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_a", {{(32-AW){1'b0}}, ram_a}, 32'd0);
    check("rst_ram_d", ram_d, 32'd0);
    @(posedge clk);
    #1;
    check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    m_last_ls = 1'b0; m_if_rdata = 32'd0; m_ls_rdata = 32'd0; m_err = 1'b0;
    m_if_wait = 1'b0; m_ls_wait = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("post_rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    check("post_rst_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    bit          ifr;
    bit          lsr;
    bit          we;
    logic [31:0] ifa;
    logic [31:0] lsa;
    logic [31:0] wd;

    reset_mid_grant();

    // single fetch read
    step(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 32'd0, 32'hDEAD_BEEF);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0BAD_F00D);

    // four-cycle conflict after reset: ls, if, ls, if
    reset_mid_grant();
    step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'h1111_1111);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0204, 32'd0, 32'h2222_2222);
    step(1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0204, 32'd0, 32'h3333_3333);
    step(1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0208, 32'd0, 32'h4444_4444);

    // legal store acknowledge keeps ls_rdata
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h9999_9999);

    // misaligned store sets err and zeroes ls_rdata; err sticks
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0022, 32'hCAFE_0000, 32'h7777_7777);
    step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 32'd0, 32'h8888_8888);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0044, 32'd0, 32'h6666_6666);

    // out-of-range load and highest legal address
    reset_mid_grant();
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h0003_FFFC, 32'd0, 32'hABCD_EF01);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h0004_0000, 32'd0, 32'h1357_9BDF);
    step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'd0, 32'd0, 32'h2468_ACE0);

    // reset in a grant cycle, then first conflict goes to ls
    reset_mid_grant();
    step(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 32'hFEED_0001);

    // randomised traffic honouring the hold-until-granted rule
    ifa = 32'd0; lsa = 32'd0; wd = 32'd0; we = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!m_if_wait) begin
        ifr = ($urandom_range(0, 3) != 0);
        ifa = {14'd0, 16'($urandom), 2'b00};
        if ($urandom_range(0, 9) == 0) ifa = $urandom;
      end else begin
        ifr = 1'b1;
      end
      if (!m_ls_wait) begin
        lsr = ($urandom_range(0, 3) != 0);
        we  = $urandom_range(0, 1) == 1;
        wd  = $urandom;
        lsa = {14'd0, 16'($urandom), 2'b00};
        if ($urandom_range(0, 9) == 0) lsa = $urandom;
      end else begin
        lsr = 1'b1;
      end
      step(ifr, ifa, lsr, we, lsa, wd, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
